// File: rtl/lcd_cmd_sched.sv
// Buffers host opcodes in a small FIFO and issues them one at a time to the LCD image controller.
// Closes the session after a completed Write; a watchdog traps a controller that stops responding.
module lcd_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] issued_cnt,
  output logic       idle,
  output logic       finished,
  output logic       err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] OP_WRITE = 3'd0;

  typedef enum logic [2:0] {
    S_INIT,
    S_READY,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FIN,
    S_ERR
  } state_t;

  state_t         state;
  logic [2:0]     mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           wr_locked;
  logic [2:0]     cur_cmd;
  logic [7:0]     wd;
  logic [7:0]     issued;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [8:0]     wd_inc;
  logic           wd_hit;
  logic           done_exit;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = host_valid && host_ready;
  assign pop    = (state == S_READY) && !empty && !lcd_busy;

  // The limit is judged against the count including the current wait cycle,
  // so the ERR transition is decided in the TIMEOUT-th cycle after the strobe.
  assign wd_inc = {1'b0, wd} + 9'd1;
  assign wd_hit = (wd_inc == 9'(TIMEOUT));

  // A Write only ends on done; everything else ends when the controller drops busy.
  assign done_exit = (cur_cmd == OP_WRITE) ? lcd_done : !lcd_busy;

  assign host_ready    = !full && !wr_locked &&
                         (state inside {S_READY, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE});
  assign lcd_cmd_valid = (state == S_ISSUE);
  assign lcd_cmd       = (state == S_ISSUE) ? cur_cmd : 3'd0;
  assign issued_cnt    = issued;
  assign idle          = (state == S_READY) && empty;
  assign finished      = (state == S_FIN);
  assign err_timeout   = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wr_locked <= 1'b0;
      cur_cmd   <= 3'd0;
      wd        <= 8'd0;
      issued    <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (host_cmd == OP_WRITE) begin
          wr_locked <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        cur_cmd <= mem[rd_ptr];
      end

      if (state == S_FIN) begin
        count <= '0;
      end else if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      case (state)
        S_INIT: begin
          if (!lcd_busy) begin
            state <= S_READY;
          end
        end
        S_READY: begin
          if (pop) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issued != 8'hFF) begin
            issued <= issued + 8'd1;
          end
          wd    <= 8'd0;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          wd <= wd_inc[7:0];
          if (lcd_busy) begin
            state <= S_WAIT_DONE;
          end else if (wd_hit) begin
            state <= S_ERR;
          end
        end
        S_WAIT_DONE: begin
          wd <= wd_inc[7:0];
          if (done_exit) begin
            state <= (cur_cmd == OP_WRITE) ? S_FIN : S_READY;
          end else if (wd_hit) begin
            state <= S_ERR;
          end
        end
        S_FIN:   state <= S_FIN;
        S_ERR:   state <= S_ERR;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: a per-cycle vector table for issue and FIFO ordering,
// plus hand sequences for the timeout tie, write lock, watchdog and mid-issue reset.
module tb_lcd_cmd_sched;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       lcd_busy;
  logic       lcd_done;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] issued_cnt;
  logic       idle;
  logic       finished;
  logic       err_timeout;

  int vecs = 0;
  int errs = 0;

  lcd_cmd_sched #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_cmd     (host_cmd),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .lcd_busy     (lcd_busy),
    .lcd_done     (lcd_done),
    .lcd_cmd      (lcd_cmd),
    .lcd_cmd_valid(lcd_cmd_valid),
    .issued_cnt   (issued_cnt),
    .idle         (idle),
    .finished     (finished),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Output word: {ready, valid, cmd[2:0], cnt[7:0], idle, finished, err}
  typedef struct {
    logic [2:0]  cmd;
    logic        vld;
    logic        busy;
    logic        done;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic [2:0] c, input logic v, input logic b, input logic d,
                              input logic rdy, input logic val, input logic [2:0] ecmd,
                              input logic [7:0] cnt, input logic eidle, input logic fin,
                              input logic err);
    vec_t r;
    r.cmd  = c;
    r.vld  = v;
    r.busy = b;
    r.done = d;
    r.exp  = {rdy, val, ecmd, cnt, eidle, fin, err};
    return r;
  endfunction

  function automatic logic [15:0] obs();
    return {host_ready, lcd_cmd_valid, lcd_cmd, issued_cnt, idle, finished, err_timeout};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (lcd_cmd_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Controller model for a non-Write command: busy for one cycle after the strobe.
  task automatic serve(input logic [2:0] want, input string name);
    bit ok;
    wait_strobe(6, ok);
    chk({name, "_strobe"}, 32'(ok), 32'd1);
    chk({name, "_cmd"}, 32'(lcd_cmd), 32'(want));
    lcd_busy = 1'b1;
    repeat (2) @(negedge clk);
    lcd_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    bit any_rdy;
    bit any_vld;

    // Basic issue, then FIFO fill to full with a refused push on a popping cycle,
    // then in-order drain; a stray done in READY is ignored.
    tbl[0]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(2, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(3, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mk(4, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(6, 1, 0, 0, 1, 1, 2, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 1, 3, 2, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 1, 0, 0, 3, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 1, 1, 4, 3, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0);
    tbl[21] = mk(0, 0, 1, 0, 1, 0, 0, 4, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 1, 1, 5, 4, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0);
    tbl[25] = mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 0, 0);
    tbl[26] = mk(0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0);
    tbl[27] = mk(0, 0, 0, 1, 1, 0, 0, 5, 1, 0, 0);

    reset = 1'b1; host_cmd = 3'd0; host_valid = 1'b0; lcd_busy = 1'b1; lcd_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values", 32'(obs()), 32'h0);
    reset = 1'b0;
    repeat (130) @(negedge clk);
    chk("init_hold", 32'(obs()), 32'h0);

    for (int i = 0; i < 28; i++) begin
      host_cmd   = tbl[i].cmd;
      host_valid = tbl[i].vld;
      lcd_busy   = tbl[i].busy;
      lcd_done   = tbl[i].done;
      @(negedge clk);
      if (obs() !== tbl[i].exp) begin
        errs++;
        $display("FAIL vec%0d: got %04h expected %04h", i, obs(), tbl[i].exp);
      end
      vecs++;
    end

    // Timeout tie: busy drops in the very cycle the watchdog reaches its limit.
    lcd_done = 1'b0; host_cmd = 3'd1; host_valid = 1'b1; lcd_busy = 1'b0;
    @(negedge clk);
    host_valid = 1'b0;
    wait_strobe(6, ok);
    chk("tie_strobe", 32'(ok), 32'd1);
    lcd_busy = 1'b1;
    repeat (TO) @(negedge clk);
    lcd_busy = 1'b0;
    @(negedge clk);
    chk("tie_ready", {29'd0, idle, err_timeout, host_ready}, 32'b101);
    repeat (5) @(negedge clk);
    chk("tie_no_err", {23'd0, err_timeout, issued_cnt}, {23'd0, 1'b0, 8'd6});

    // Write lock: Left, Write accepted; Right refused; Write completes with done.
    chk("wl_ready_before", 32'(host_ready), 32'd1);
    host_cmd = 3'd3; host_valid = 1'b1; lcd_busy = 1'b1;
    @(negedge clk);
    host_cmd = 3'd0;
    @(negedge clk);
    chk("wl_locked", 32'(host_ready), 32'd0);
    host_cmd = 3'd4;
    @(negedge clk);
    host_valid = 1'b0; lcd_busy = 1'b0;
    serve(3'd3, "wl_left");
    wait_strobe(6, ok);
    chk("wl_write_strobe", {28'd0, ok, lcd_cmd}, {28'd0, 1'b1, 3'd0});
    lcd_busy = 1'b1;
    repeat (70) @(negedge clk);
    chk("wl_not_yet", 32'(finished), 32'd0);
    lcd_done = 1'b1;
    @(negedge clk);
    lcd_done = 1'b0;
    chk("wl_finished", {28'd0, finished, err_timeout, host_ready, idle}, 32'b1000);
    any_rdy = 1'b0; any_vld = 1'b0;
    host_cmd = 3'd1; host_valid = 1'b1; lcd_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_rdy |= host_ready;
      any_vld |= lcd_cmd_valid;
    end
    host_valid = 1'b0;
    chk("wl_terminal", {22'd0, any_rdy, any_vld, issued_cnt}, {22'd0, 1'b0, 1'b0, 8'd8});

    // Watchdog: Average issued, controller never raises busy.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lcd_busy = 1'b0;
    @(negedge clk);
    host_cmd = 3'd5; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    wait_strobe(6, ok);
    chk("wd_strobe", {28'd0, ok, lcd_cmd}, {28'd0, 1'b1, 3'd5});
    repeat (TO) @(negedge clk);
    chk("wd_before_limit", 32'(err_timeout), 32'd0);
    @(negedge clk);
    chk("wd_fired", {30'd0, err_timeout, finished}, 32'b10);
    any_rdy = 1'b0; any_vld = 1'b0;
    host_cmd = 3'd2; host_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      any_rdy |= host_ready;
      any_vld |= lcd_cmd_valid;
    end
    host_valid = 1'b0;
    chk("wd_terminal", {21'd0, any_rdy, any_vld, err_timeout, issued_cnt},
        {21'd0, 1'b0, 1'b0, 1'b1, 8'd1});

    // Reset asserted while a strobe is on the wire.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; lcd_busy = 1'b1;
    repeat (3) @(negedge clk);
    lcd_busy = 1'b0;
    @(negedge clk);
    host_cmd = 3'd4; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    serve(3'd4, "rst_first");
    @(negedge clk);
    host_cmd = 3'd7; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    wait_strobe(6, ok);
    chk("rst_pre_strobe", {20'd0, ok, lcd_cmd, issued_cnt}, {20'd0, 1'b1, 3'd7, 8'd1});
    #1 reset = 1'b1;
    #1 chk("rst_mid_issue", 32'(obs()), 32'h0);
    @(negedge clk);
    reset = 1'b0; lcd_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_back_in_init", 32'(obs()), 32'h0);
    lcd_busy = 1'b0;
    @(negedge clk);
    chk("rst_ready_empty", 32'(obs()), 32'({1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0}));
    host_cmd = 3'd1; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    serve(3'd1, "rst_restart");
    @(negedge clk);
    chk("rst_fifo_lost", {23'd0, idle, issued_cnt}, {23'd0, 1'b1, 8'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler between the host command source and the LCD image controller. It buffers host commands in a small FIFO and issues them one at a time over the controller's `cmd`/`cmd_valid`/`busy` handshake. It closes the session after a Write command completes with `done`, and flags a stalled controller with a watchdog.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in entries. Must be a power of 2, range 2..16.
- TIMEOUT, 200: watchdog limit in cycles, range 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- host_cmd  in  3  command opcode: 0 Write, 1 Up, 2 Down, 3 Left, 4 Right, 5 Average, 6 MirrorX, 7 MirrorY.
- host_valid  in  1  host offers `host_cmd` this cycle.
- host_ready  out  1  scheduler accepts this cycle. A push happens when `host_valid && host_ready`.
- lcd_busy  in  1  controller `busy`.
- lcd_done  in  1  controller `done`.
- lcd_cmd  out  3  opcode driven to the controller.
- lcd_cmd_valid  out  1  one-cycle issue strobe.
- issued_cnt  out  8  number of commands issued; saturates at 255.
- idle  out  1  state is READY and the FIFO is empty.
- finished  out  1  Write completed; sticky.
- err_timeout  out  1  watchdog fired; sticky.

## Operation
- FIFO: DEPTH entries of 3 bits; registered count, read and write pointers; pointers wrap modulo DEPTH.
- `host_ready` = not full AND wr_locked = 0 AND state in {READY, ISSUE, WAIT_ACK, WAIT_DONE}.
  - Full is the registered full flag. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- wr_locked: set on accepting a Write. While set, no further commands are accepted. Cleared only by reset.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- FSM states: INIT, READY, ISSUE, WAIT_ACK, WAIT_DONE, FIN, ERR.
  - INIT: wait for `lcd_busy` = 0 (image load finished), then go to READY. No watchdog in INIT.
  - READY: if the FIFO is non-empty and `lcd_busy` = 0, pop the head into the cur_cmd register and go to ISSUE. Otherwise stay.
  - ISSUE: `lcd_cmd_valid` = 1 and `lcd_cmd` = cur_cmd for exactly this one cycle. `issued_cnt` increments. Next state is WAIT_ACK.
  - WAIT_ACK: when `lcd_busy` = 1, go to WAIT_DONE.
  - WAIT_DONE:
    - For a non-Write cur_cmd: when `lcd_busy` = 0, go to READY.
    - For a Write cur_cmd: when `lcd_done` = 1, go to FIN; `lcd_busy` is ignored.
  - FIN: `finished` = 1. Terminal state. Remaining FIFO contents are discarded (count forced to 0).
  - ERR: `err_timeout` = 1. Terminal state. `lcd_cmd_valid` is held at 0.
- Watchdog: 8-bit counter.
  - Cleared on entering WAIT_ACK.
  - Increments each cycle in WAIT_ACK or WAIT_DONE.
  - When it equals TIMEOUT and no exit condition holds that cycle, the next state is ERR.
  - If an exit condition and the timeout coincide, the exit condition wins.
- `lcd_done` seen in any state other than WAIT_DONE-with-Write is ignored.

## Timing
- Reset values: `host_ready`=0, `lcd_cmd`=0, `lcd_cmd_valid`=0, `issued_cnt`=0, `idle`=0, `finished`=0, `err_timeout`=0. FIFO is empty, state is INIT, wr_locked=0.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Latency from push into an empty FIFO (state READY, `lcd_busy`=0) to `lcd_cmd_valid`:
  - entry is written at edge N;
  - READY sees the FIFO non-empty in cycle N+1;
  - ISSUE, with the strobe high, is cycle N+2.
- Back-to-back: the next issue is no earlier than 2 cycles after `lcd_busy` falls (one cycle READY, then ISSUE).
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - A strobe in progress is dropped.
  - FIFO contents are lost.

## Test plan
- Basic issue: after reset, `lcd_busy`=1 for 130 cycles, then 0. Push Up. Expected:
  - `lcd_cmd_valid` pulses 1 cycle with `lcd_cmd`=1, 2 cycles after the push;
  - `issued_cnt`=1;
  - `idle`=1 once the model drops `busy`.
- FIFO full: hold `lcd_busy`=1 in READY and push 5 commands with DEPTH=4. Expected:
  - 4 are accepted and `host_ready`=0 on the 5th;
  - release busy: commands issue in FIFO order, one per handshake.
- Write lock: push Left, Write, Right. Expected:
  - Right is refused (`host_ready`=0 after Write is accepted);
  - Left then Write are issued;
  - model raises `lcd_done` 70 cycles after the Write issue, then `finished`=1 and `host_ready`=0 permanently.
- Watchdog: issue Average and hold `lcd_busy`=0 forever with TIMEOUT=10. Expected: `err_timeout`=1 11 cycles after the strobe, no further strobes.
- Timeout/exit tie: `lcd_busy` falls in the exact cycle the counter hits TIMEOUT. Expected: READY is entered and `err_timeout` stays 0.
- Async reset: assert reset during ISSUE. Expected: `lcd_cmd_valid`=0 in the same cycle, all outputs at reset values, and the sequence restarts from INIT.
